// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : Registered, opcode-selected ALU with carry/zero flags and an
//               optional iterative shift-add multiplier (busy/done handshake).
// Revision    : 1.0  initial release
// ============================================================================
module alu_unit #(
    parameter int WIDTH  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Rd1,
    input  logic [WIDTH-1:0] Rd2,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int             c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 1);
    localparam logic           c_mul_en    = (MUL_EN != 0);

    localparam logic [2:0] c_op_and = 3'b000;
    localparam logic [2:0] c_op_or  = 3'b001;
    localparam logic [2:0] c_op_xor = 3'b010;
    localparam logic [2:0] c_op_not = 3'b011;
    localparam logic [2:0] c_op_add = 3'b100;
    localparam logic [2:0] c_op_sub = 3'b101;
    localparam logic [2:0] c_op_shl = 3'b110;
    localparam logic [2:0] c_op_mul = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_result;
    logic                   r_carry;
    logic                   r_zero;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [c_cnt_w-1:0]     r_cnt;

    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [2*WIDTH-1:0]     w_shl;
    logic [WIDTH-1:0]       w_res;
    logic                   w_carry;
    logic [2*WIDTH-1:0]     w_acc_next;
    logic                   w_mul_hi_nz;

    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

    // Single-cycle result and flag, computed straight from the request inputs.
    // The shift is done in a double-width field so bit WIDTH is always the last
    // bit shifted out, and amounts beyond WIDTH naturally yield zero.
    always_comb begin
        w_add   = {1'b0, Rd1} + {1'b0, Rd2};
        w_sub   = {1'b0, Rd1} - {1'b0, Rd2};
        w_shl   = {{WIDTH{1'b0}}, Rd1} << Rd2;
        w_res   = '0;
        w_carry = 1'b0;
        case (op)
            c_op_and: w_res = Rd1 & Rd2;
            c_op_or:  w_res = Rd1 | Rd2;
            c_op_xor: w_res = Rd1 ^ Rd2;
            c_op_not: w_res = ~Rd1;
            c_op_add: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
            end
            c_op_sub: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
            end
            c_op_shl: begin
                w_res   = w_shl[WIDTH-1:0];
                w_carry = w_shl[WIDTH];
            end
            default: begin
                w_res   = '0;
                w_carry = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mul_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered outputs and multiplier datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (en) begin
                        if (c_mul_en && (op == c_op_mul)) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, Rd1};
                            r_mplier <= Rd2;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_MUL;
                        end else begin
                            r_result <= w_res;
                            r_carry  <= w_carry;
                            r_zero   <= (w_res == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    r_done   <= 1'b0;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_iter) begin
                        r_result <= w_acc_next[WIDTH-1:0];
                        r_carry  <= w_mul_hi_nz;
                        r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Self-checking bench for alu_unit (multiplier and no-multiplier
//               builds) with directed cases and randomized operations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_unit;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] Rd1;
    logic [WIDTH-1:0] Rd2;

    logic [WIDTH-1:0] result,  result0;
    logic             carry,   carry0;
    logic             zero,    zero0;
    logic             busy,    busy0;
    logic             done,    done0;

    int n_checks = 0;
    int n_errors = 0;
    int exp_res  = 0;
    int exp_c    = 0;
    int exp_z    = 0;
    bit busy0_seen = 0;

    alu_unit #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .Rd1(Rd1), .Rd2(Rd2),
        .result(result), .carry(carry), .zero(zero), .busy(busy), .done(done)
    );

    alu_unit #(.WIDTH(WIDTH), .MUL_EN(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .op(op), .Rd1(Rd1), .Rd2(Rd2),
        .result(result0), .carry(carry0), .zero(zero0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (busy0 === 1'b1) busy0_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the opcode table, plain integer arithmetic.
    function automatic void model(input int o, input int a, input int b,
                                  input bit mul_en, output int r, output int c);
        int p;
        r = 0; c = 0;
        case (o)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: r = (~a) & MASK;
            4: begin p = a + b; r = p % (MASK + 1); c = (p > MASK) ? 1 : 0; end
            5: begin r = (a - b + MASK + 1) % (MASK + 1); c = (a < b) ? 1 : 0; end
            6: begin
                if (b == 0) r = a;
                else if (b <= WIDTH) begin
                    p = a * (1 << b);
                    r = p % (MASK + 1);
                    c = (p / (MASK + 1)) % 2;
                end
            end
            default: begin
                if (mul_en) begin
                    p = a * b;
                    r = p % (MASK + 1);
                    c = (p > MASK) ? 1 : 0;
                end
            end
        endcase
    endfunction

    task automatic single(input int o, input int a, input int b);
        int r, c;
        @(negedge clk);
        en = 1'b1; op = 3'(o); Rd1 = WIDTH'(a); Rd2 = WIDTH'(b);
        @(posedge clk); #1;
        model(o, a, b, 1'b1, r, c);
        exp_res = r; exp_c = c; exp_z = (r == 0) ? 1 : 0;
        check("done",   done,   1);
        check("result", result, exp_res);
        check("carry",  carry,  exp_c);
        check("zero",   zero,   exp_z);
        check("busy",   busy,   0);
        check("nm_result", result0, exp_res);
        check("nm_carry",  carry0,  exp_c);
        check("nm_done",   done0,   1);
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("idle_done",   done,   0);
        check("idle_result", result, exp_res);
        check("idle_carry",  carry,  exp_c);
        check("idle_zero",   zero,   exp_z);
    endtask

    task automatic do_mul(input int a, input int b, input bit inject);
        int r, c, busy_cnt, done_cnt;
        bit got, overlap;
        @(negedge clk);
        en = 1'b1; op = 3'd7; Rd1 = WIDTH'(a); Rd2 = WIDTH'(b);
        @(posedge clk); #1;
        check("mul_busy0", busy, 1);
        check("mul_done0", done, 0);
        check("nm_mul_done",   done0,   1);
        check("nm_mul_result", result0, 0);
        check("nm_mul_carry",  carry0,  0);
        check("nm_mul_zero",   zero0,   1);
        busy_cnt = 1; done_cnt = 0; got = 0; overlap = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (inject && i == 0) begin
                en = 1'b1; op = 3'd0; Rd1 = '1; Rd2 = '1;
            end else begin
                en = 1'b0;
            end
            @(posedge clk); #1;
            if (busy && done) overlap = 1;
            if (busy) busy_cnt++;
            if (done) begin got = 1; done_cnt++; end
        end
        model(7, a, b, 1'b1, r, c);
        exp_res = r; exp_c = c; exp_z = (r == 0) ? 1 : 0;
        check("mul_completed", got, 1);
        check("mul_busy_cycles", busy_cnt, WIDTH);
        check("mul_overlap", overlap, 0);
        check("mul_result", result, exp_res);
        check("mul_carry",  carry,  exp_c);
        check("mul_zero",   zero,   exp_z);
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        if (done) done_cnt++;
        check("mul_single_done", done_cnt, 1);
        check("mul_hold", result, exp_res);
    endtask

    task automatic reset_mid_mul();
        int done_seen;
        @(negedge clk);
        en = 1'b1; op = 3'd7; Rd1 = 4'd7; Rd2 = 4'd3;
        @(posedge clk); #1;
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        check("rmm_busy2", busy, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rmm_result", result, 0);
        check("rmm_carry",  carry,  0);
        check("rmm_zero",   zero,   0);
        check("rmm_busy",   busy,   0);
        check("rmm_done",   done,   0);
        exp_res = 0; exp_c = 0; exp_z = 0;
        @(negedge clk); rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("rmm_no_done", done_seen, 0);
        single(0, 12, 10);
        check("rmm_and_result", result, 8);
    endtask

    task automatic rst_with_en();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; op = 3'd4; Rd1 = 4'd3; Rd2 = 4'd4;
        @(posedge clk); #1;
        check("rst_en_done",   done,   0);
        check("rst_en_result", result, 0);
        exp_res = 0; exp_c = 0; exp_z = 0;
        @(negedge clk); rst = 1'b0; en = 1'b0;
        @(posedge clk); #1;
        check("rst_en_dropped", done, 0);
    endtask

    initial begin
        int sel, o;
        rst = 1'b1; en = 1'b0; op = '0; Rd1 = '0; Rd2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_carry",  carry,  0);
        check("rst_zero",   zero,   0);
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        @(negedge clk); rst = 1'b0;

        // Directed cases.
        single(0, 4'b1100, 4'b1010);
        check("and_value", result, 4'b1000);
        idle();
        single(4, 15, 1);
        check("add_wrap", {carry, zero, result}, {1'b1, 1'b1, 4'h0});
        single(5, 3, 5);
        check("sub_borrow", {carry, zero, result}, {1'b1, 1'b0, 4'hE});
        single(6, 4'b0110, 2);
        check("shl2", {carry, result}, {1'b1, 4'b1000});
        single(6, 4'b0110, 5);
        check("shl5", {carry, zero, result}, {1'b0, 1'b1, 4'h0});
        single(6, 4'b1001, 4);
        check("shl4", {carry, result}, {1'b1, 4'h0});
        idle();
        do_mul(7, 3, 1'b1);
        check("mul73", {carry, result}, {1'b1, 4'b0101});
        do_mul(15, 15, 1'b0);
        do_mul(0, 9, 1'b0);
        reset_mid_mul();
        rst_with_en();

        // Randomized operations, including back-to-back issue with en held.
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                idle();
            end else begin
                o = $urandom_range(0, 7);
                if (o == 7) do_mul($urandom_range(0, MASK), $urandom_range(0, MASK),
                                   1'($urandom_range(0, 1)));
                else single(o, $urandom_range(0, MASK), $urandom_range(0, MASK));
            end
        end
        idle();
        check("nm_busy_never", busy0_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_unit.md
# alu_unit

Parametrised, registered ALU for the datapath of the course processor project. It succeeds the standalone 4-bit enable-gated logic gates (AND and similar) with one opcode-selected unit. The unit takes two register operands (`Rd1`, `Rd2`) plus an opcode, and returns a registered result with carry and zero flags. Single-cycle ops complete in one clock; the optional multiply is a multi-cycle shift-add with a busy/done handshake toward the control FSM.

## Interface
- `WIDTH`, default 4: operand and result width; legal range 2..16.
- `MUL_EN`, default 1: 1 builds the iterative multiplier; 0 removes it.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: operation request; sampled only in IDLE.
- `op`  in  3: opcode, captured with `en`.
- `Rd1`  in  WIDTH: operand A, captured with `en`.
- `Rd2`  in  WIDTH: operand B, captured with `en`.
- `result`  out  WIDTH: registered result; holds its value until the next completion.
- `carry`  out  1: registered carry/borrow/overflow flag.
- `zero`  out  1: registered; high when `result` == 0 at completion.
- `busy`  out  1: high while a multiply is iterating.
- `done`  out  1: one-cycle pulse marking the cycle in which `result`/`carry`/`zero` are updated.

## Operation
- FSM states: IDLE, MUL. Reset and any undefined state go to IDLE.
- IDLE, `en`=1, op≠111 (or `MUL_EN`=0): compute, register outputs, pulse `done`; stay in IDLE.
- IDLE, `en`=1, op=111, `MUL_EN`=1: latch operands, clear accumulator and counter, go to MUL, raise `busy`.
- MUL: one multiplier bit per cycle, LSB first. The accumulator is 2·WIDTH bits wide. After WIDTH iterations: register outputs, pulse `done`, drop `busy`, return to IDLE.
- `en` while in MUL is ignored; it is neither queued nor acknowledged.
- `en`=0 in IDLE: outputs hold, `done`=0.
- Opcodes (all arithmetic is mod 2^WIDTH):
  - 000 AND, 001 OR, 010 XOR: `carry`=0.
  - 011 NOT `Rd1`: `carry`=0.
  - 100 ADD: `carry` = carry-out of bit WIDTH-1.
  - 101 SUB `Rd1`−`Rd2`: `carry` = borrow (1 iff `Rd1` < `Rd2`, unsigned).
  - 110 SHL `Rd1` by `Rd2` (unsigned amount):
    - amount 0: result = `Rd1`, `carry`=0.
    - 1..WIDTH: `carry` = `Rd1`[WIDTH−amount], the last bit shifted out.
    - amount > WIDTH: result 0, `carry`=0.
  - 111 MUL: result = low WIDTH bits of the product; `carry` = 1 iff any upper product bit is nonzero. With `MUL_EN`=0, op 111 completes in one cycle with result 0, `carry`=0, `zero`=1.
- `zero` is recomputed at every completion from the new result.

## Timing
- Reset values: `result`=0, `carry`=0, `zero`=0, `busy`=0, `done`=0; state IDLE; counter 0.
- Single-cycle op with `en` sampled at edge E0: new outputs and `done`=1 are visible after E0; `done` returns to 0 after E1 unless a new `en` arrives in IDLE.
- Back-to-back single-cycle ops, `en` held high: one completion per cycle, `done` stays high.
- MUL with `en` at E0: `busy`=1 after E0. Iterations occur at E1..E_WIDTH. After E_WIDTH, outputs update, `done`=1 and `busy`=0. Latency is WIDTH cycles.
- A new `en` is accepted at E_WIDTH+1 at the earliest; `done` and `busy` are never high together.
- `rst` mid-MUL: aborts at that edge. All outputs go to reset values, no `done`, and operands are discarded.
- `rst` and `en` in the same cycle: `rst` wins and the request is dropped.
- Operands and `op` need only be valid in the cycle `en` is sampled.

## Test plan
- AND, WIDTH=4: `Rd1`=1100, `Rd2`=1010, `en` one cycle → next cycle `result`=1000, `carry`=0, `zero`=0, `done` pulse one cycle wide.
- ADD 4'hF+4'h1 → `result`=0, `carry`=1, `zero`=1. Then SUB 3−5 → `result`=4'hE, `carry`=1, `zero`=0.
- SHL: 0110 by 2 → `result`=1000, `carry`=1. Then 0110 by 5 → `result`=0, `carry`=0, `zero`=1.
- MUL 7×3 (product 0x15):
  - `busy` high for exactly 4 cycles; then `result`=0101, `carry`=1, `done` pulse.
  - An `en`+AND pulse injected during `busy` is ignored: only one `done` appears and the result is still 0101.
- Reset mid-MUL: assert `rst` on the 2nd `busy` cycle → next cycle all outputs 0 and no `done` later. An AND issued the cycle after `rst` is released completes normally.
- `MUL_EN`=0 build: op 111 with 7×3 → one-cycle completion, `result`=0, `carry`=0, `zero`=1, `busy` never high.
